dbus_sequencer: RTL and testbench

//  Sequences data-bus accesses for the memory stage. Latches one load/store, drives a stable dbus_req_t

---
 rtl/dbus_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_dbus_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_sequencer.sv
// Data-bus access sequencer: one outstanding load/store, byte-lane alignment, timeout.
// Optional DBUS_MISALIGN_CHECK_EN rejects misaligned accesses without touching the bus.
package dbus_pkg;
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_sequencer
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  msize_t      req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic          write_q;
  logic [63:0]   addr_q;
  msize_t        size_q;
  logic          signed_q;
  logic [63:0]   wdata_q;
  logic          killed_q;
  logic [CW-1:0] cnt_q;
  logic [63:0]   rdata_q;
  logic          err_q;

  logic [5:0]  shamt;
  logic [7:0]  bmask;
  logic [63:0] x;
  logic [63:0] ext;
  logic [63:0] ld_data;
  logic        to_hit;
  logic        unused_addr_ok;

  assign unused_addr_ok = dresp.addr_ok;
  assign shamt = {addr_q[2:0], 3'b000};

  always_comb begin
    bmask = 8'h00;
    unique case (size_q)
      MSIZE1:  bmask = 8'h01;
      MSIZE2:  bmask = 8'h03;
      MSIZE4:  bmask = 8'h0f;
      MSIZE8:  bmask = 8'hff;
      default: bmask = 8'h00;
    endcase
  end

  // Bus request is a pure function of latched state, so it is constant in WAIT.
  always_comb begin
    dreq = '0;
    if (state_q == WAIT) begin
      dreq.valid = 1'b1;
      dreq.addr  = addr_q;
      dreq.size  = size_q;
      if (write_q) begin
        dreq.strobe = bmask << addr_q[2:0];
        dreq.data   = wdata_q << shamt;
      end
    end
  end

  always_comb begin
    x   = dresp.data >> shamt;
    ext = x;
    unique case (size_q)
      MSIZE1:  ext = {{56{signed_q & x[7]}}, x[7:0]};
      MSIZE2:  ext = {{48{signed_q & x[15]}}, x[15:0]};
      MSIZE4:  ext = {{32{signed_q & x[31]}}, x[31:0]};
      default: ext = x;
    endcase
    ld_data = write_q ? 64'd0 : ext;
  end

  assign to_hit = (TIMEOUT_CYCLES != 0) &&
                  (cnt_q == CW'(TIMEOUT_CYCLES - 1));

`ifdef DBUS_MISALIGN_CHECK_EN
  logic mis;
  always_comb begin
    mis = 1'b0;
    unique case (req_size)
      MSIZE2:  mis = req_addr[0];
      MSIZE4:  mis = |req_addr[1:0];
      MSIZE8:  mis = |req_addr[2:0];
      default: mis = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      size_q   <= MSIZE1;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      killed_q <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          killed_q <= 1'b0;
          cnt_q    <= '0;
          if (req_valid && !flush) begin
            write_q  <= req_write;
            addr_q   <= req_addr;
            size_q   <= req_size;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
`ifdef DBUS_MISALIGN_CHECK_EN
            if (mis) begin
              state_q <= DONE;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state_q <= WAIT;
            end
`else
            state_q <= WAIT;
`endif
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (flush) killed_q <= 1'b1;
          if (dresp.data_ok) begin
            rdata_q <= ld_data;
            err_q   <= 1'b0;
            state_q <= DONE;
          end else if (to_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          killed_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall      = (state_q == IDLE) ? req_valid : (state_q == WAIT);
  assign resp_valid = (state_q == DONE) && !killed_q && !flush;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dbus_sequencer.sv
// Randomized scoreboard bench for dbus_sequencer against a byte-lane reference model.
// Build with +define+DBUS_MISALIGN_CHECK_EN to cover the misalignment reject path.
module tb_dbus_sequencer;
  import dbus_pkg::*;

  localparam int TO = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  msize_t      req_size = MSIZE1;
  logic        req_signed = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  dbus_req_t   dreq;
  dbus_resp_t  dresp = '0;

  dbus_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata),
    .flush(flush), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dreq(dreq), .dresp(dresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [63:0] rdata;
    bit          chk_rdata;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  dbus_req_t   exp_dreq = '0;
  bit          exp_no_dreq = 0;
  int          plan_lat = 0;
  logic [63:0] plan_data = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ld_model(input msize_t sz, input bit sg,
                                           input int off,
                                           input logic [63:0] d);
    int          n;
    logic [63:0] xv, mask, v;
    n  = 1 << int'(sz);
    xv = d >> (8 * off);
    if (n >= 8) return xv;
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = xv & mask;
    if (sg && xv[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Bus responder: data_ok on the plan_lat-th WAIT cycle, noise otherwise.
  int k = 0;
  always @(negedge clk) begin
    if (dreq.valid) begin
      dresp.data_ok = (k == plan_lat);
      dresp.data    = (k == plan_lat) ? plan_data : {$urandom, $urandom};
      dresp.addr_ok = 1'($urandom);
      k++;
    end else begin
      k = 0;
      dresp.data_ok = ($urandom % 3 == 0);
      dresp.data    = {$urandom, $urandom};
      dresp.addr_ok = 1'($urandom);
    end
  end

  // Monitor: dreq content while valid, and scoreboard pops on resp_valid.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset) begin
      if (dreq.valid) begin
        if (exp_no_dreq) chk("dreq_unexpected", 64'(dreq.valid), 64'd0);
        chk("dreq_addr", dreq.addr, exp_dreq.addr);
        chk("dreq_size", 64'(dreq.size), 64'(exp_dreq.size));
        chk("dreq_strobe", 64'(dreq.strobe), 64'(exp_dreq.strobe));
        chk("dreq_data", dreq.data, exp_dreq.data);
        chk("stall_wait", 64'(stall), 64'd1);
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 64'(resp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_err", 64'(resp_err), 64'(e.err));
          if (e.chk_rdata) chk("resp_rdata", resp_rdata, e.rdata);
        end
      end
    end
  end

  // mode: 0 plain, 1 flush in WAIT cycle j, 2 flush in DONE, 3 reset in WAIT cycle j
  task automatic do_req(input bit wr, input logic [63:0] addr,
                        input msize_t sz, input bit sg,
                        input logic [63:0] wd, input int lat,
                        input logic [63:0] bd, input int mode, input int j);
    int   n, off, wlen, s, c, jj;
    bit   skip, kill;
    exp_t e;
    n    = 1 << int'(sz);
    off  = int'(addr % 8);
    wlen = (lat < TO) ? lat + 1 : TO;
    jj   = j % wlen;
    skip = 0;
`ifdef DBUS_MISALIGN_CHECK_EN
    skip = (addr % n) != 0;
`endif
    s = ((1 << n) - 1) << off;
    exp_dreq.valid  = 1'b1;
    exp_dreq.addr   = addr;
    exp_dreq.size   = sz;
    exp_dreq.strobe = wr ? s[7:0] : 8'h00;
    exp_dreq.data   = wr ? (wd << (8 * off)) : 64'd0;
    exp_no_dreq     = skip;
    plan_lat  = lat;
    plan_data = bd;
    kill = (mode == 2) || (!skip && (mode == 1 || mode == 3));
    if (!kill) begin
      if (skip) begin
        e.err = 1; e.rdata = '0; e.chk_rdata = 1;
      end else if (lat < TO) begin
        e.err = 0; e.chk_rdata = 1;
        e.rdata = wr ? 64'd0 : ld_model(sz, sg, off, bd);
      end else begin
        e.err = 1; e.rdata = '0; e.chk_rdata = 0;
      end
      sb.push_back(e);
    end
    req_valid = 1; req_write = wr; req_addr = addr;
    req_size = sz; req_signed = sg; req_wdata = wd; flush = 0;
    #1 chk("stall_idle", 64'(stall), 64'd1);
    for (c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!stall) break;
      flush = (mode == 1) && (c == jj);
      if (mode == 3 && c == jj) begin
        #3 reset = 0;
        req_valid = 0;
        #1 chk("reset_drops_dreq", 64'(dreq.valid), 64'd0);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        reset = 1;
        return;
      end
    end
    if (c == 60) chk("done_budget", 64'(c), 64'd0);
    flush = (mode == 2);
    req_valid = 0;
    @(negedge clk);
    flush = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [63:0] a, d, w;
    msize_t      sz;
    int          lat, mode;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_dreq_valid", 64'(dreq.valid), 64'd0);
    @(negedge clk);
    reset = 1;
    do_req(0, 64'h8000_0004, MSIZE4, 1, '0, 2, 64'hFFFF_FFFF_8000_0000, 0, 0);
    do_req(1, 64'h1000_0003, MSIZE2, 0, 64'hBEEF, 0, '0, 0, 0);
    do_req(0, 64'h2000_0007, MSIZE1, 0, '0, 1, 64'h8011_2233_4455_6677, 0, 0);
    do_req(0, 64'h2000_0007, MSIZE1, 1, '0, 1, 64'h8011_2233_4455_6677, 0, 0);
    do_req(0, 64'h3000_0000, MSIZE8, 0, '0, TO + 3, 64'h1, 0, 0);
    do_req(0, 64'h3000_0008, MSIZE8, 0, '0, TO - 1, 64'hDEAD_BEEF_0BAD_F00D, 0, 0);
    do_req(1, 64'h3000_0010, MSIZE8, 0, 64'h1234, TO, '0, 0, 0);
    do_req(0, 64'h4000_0000, MSIZE4, 0, '0, 4, 64'h5, 1, 1);
    do_req(0, 64'h4000_0004, MSIZE4, 0, '0, 2, 64'h6, 2, 0);
    do_req(1, 64'h5000_0002, MSIZE4, 0, 64'hCAFE_F00D, 1, '0, 0, 0);
    do_req(0, 64'h6000_0000, MSIZE8, 0, '0, TO + 3, '0, 3, 2);
    req_valid = 1; flush = 1; req_addr = 64'h8; req_size = MSIZE8;
    @(negedge clk);
    req_valid = 0; flush = 0;
    #1 chk("flush_idle_no_dreq", 64'(dreq.valid), 64'd0);
    @(negedge clk);
    for (int i = 0; i < 150; i++) begin
      sz   = msize_t'($urandom_range(0, 3));
      a    = {$urandom, $urandom};
      if ($urandom % 2 == 0) a = a & ~64'((1 << int'(sz)) - 1);
      d    = {$urandom, $urandom};
      w    = {$urandom, $urandom};
      lat  = $urandom_range(0, TO + 1);
      mode = $urandom_range(0, 9);
      mode = (mode < 7) ? 0 : (mode < 8) ? 1 : 2;
      do_req(1'($urandom), a, sz, 1'($urandom), w, lat, d, mode,
             $urandom_range(0, TO));
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
